// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronized line, mid-bit sampling, LSB first,
// framing-error detection with a BREAK state that waits for the line to return high.
module uart_rx #(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_in,
    output logic [7:0] dout,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] fsm_state
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // Output handshake: rx_valid is a one-cycle strobe with no back-pressure;
    // dout changes only on that strobe and holds until the next one.

    logic          sync_q, rx_s;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    dout_n;
    logic          valid_n, ferr_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_q <= rx_in;
            rx_s   <= sync_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= 3'd0;
            shreg     <= 8'h00;
            dout      <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            dout      <= dout_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        dout_n  = dout;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n = S_START;
                    cnt_n   = '0;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    idx_n   = 3'd0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_n = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n        = '0;
                    shreg_n[idx] = rx_s;
                    idx_n        = idx + 3'd1;
                    if (idx == 3'd7)
                        state_n = S_STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        dout_n  = shreg;
                        valid_n = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_BREAK: begin
                if (rx_s)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 2604, meaning clk cycles per serial bit (25 MHz / 9600 baud).
REQ-002 The block SHALL derive HALF_BIT = CLKS_PER_BIT/2 (integer divide, 1302 at default), meaning the mid-bit sample offset.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge only.
REQ-004 The block SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port rx_in, input, 1, asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 The block SHALL have port dout, output, 8, last correctly framed received byte.
REQ-007 The block SHALL have port rx_valid, output, 1, one-cycle pulse marking a new dout.
REQ-008 The block SHALL have port frame_err, output, 1, one-cycle pulse marking a stop bit sampled low.
REQ-009 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-010 rx_in SHALL pass through a 2-flop synchronizer (both flops reset to 1) before any use; all line decisions SHALL use the synchronized value rx_s.
REQ-011 The state machine SHALL have states IDLE, START, DATA, STOP, BREAK, plus a bit counter (0..CLKS_PER_BIT-1), a bit index (0..7) and an 8-bit shift register.
REQ-012 IDLE: when rx_s = 0, SHALL go to START with the bit counter cleared; otherwise remain.
REQ-013 START: when the bit counter reaches HALF_BIT-1, SHALL sample rx_s; 0 -> DATA with counter and bit index cleared; 1 -> IDLE (glitch reject, no output pulse).
REQ-014 DATA: when the bit counter reaches CLKS_PER_BIT-1, SHALL sample rx_s into shift-register bit [bit index] (LSB first), clear the counter, and increment the bit index; after index 7 is sampled, SHALL go to STOP.
REQ-015 STOP: when the bit counter reaches CLKS_PER_BIT-1, SHALL sample rx_s; 1 -> load dout from the shift register, pulse rx_valid for exactly one cycle, go to IDLE; 0 -> pulse frame_err for exactly one cycle, leave dout unchanged, go to BREAK.
REQ-016 BREAK: SHALL remain until rx_s = 1, then go to IDLE; a line held low SHALL produce exactly one frame_err and no rx_valid.
REQ-017 rx_valid and frame_err SHALL never be asserted in the same cycle and SHALL be low in all other cycles.
REQ-018 The bit counter SHALL never exceed CLKS_PER_BIT-1 and SHALL wrap to 0 at each sample point.
REQ-019 Because the stop bit is sampled at mid-bit and IDLE is re-entered immediately, a start bit arriving right after a one-bit-time stop bit SHALL be received (back-to-back frames, no idle gap required).
REQ-020 rx_valid SHALL rise 2 + HALF_BIT + 9*CLKS_PER_BIT cycles (+/-2) after the falling edge of the start bit on rx_in.
REQ-021 dout SHALL hold its value between rx_valid pulses, including across glitches and framing errors.

Reset
REQ-022 While rstn = 0, the block SHALL force state IDLE, counter 0, bit index 0, shift register 0x00, dout 0x00, rx_valid 0, frame_err 0, busy 0, synchronizer flops 1, regardless of clk.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame with no output pulse; after release, the first frame starting from an idle-high line SHALL be received correctly.

Verification
REQ-024 Send 0xA5 at CLKS_PER_BIT=2604, stop=1 -> dout = 0xA5, one rx_valid pulse at the REQ-020 time, frame_err never high.
REQ-025 Drive rx_in low for 500 cycles, then high -> busy pulses, returns to IDLE, no rx_valid/frame_err, dout unchanged.
REQ-026 After receiving 0x3C, send 0x81 with stop bit = 0, then line high -> one frame_err pulse, dout remains 0x3C, BREAK exited, next frame 0x55 received.
REQ-027 Send 0x00 then 0xFF back-to-back, one-bit stop, no gap -> two rx_valid pulses, dout 0x00 then 0xFF.
REQ-028 Assert rstn low during bit 4 of 0x5A, release, send 0xC3 -> all outputs 0 during reset, no pulse for 0x5A, dout = 0xC3 with one rx_valid.
REQ-029 Hold rx_in low for 20 bit times, then high, then send 0x7E -> exactly one frame_err, no rx_valid until 0x7E, then dout = 0x7E.
